// File: rtl/rv32_multicycle_ctrl.sv
// rv32_multicycle_ctrl: multi-cycle control FSM for an RV32I core sharing one
// memory port between instruction fetch and data access.
// Optional build macro CTRL_PERF_CNT_EN adds cycle_cnt / instret_cnt ports.
module rv32_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic [2:0]  imm_type,
  output logic        trap,
  output logic [2:0]  state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  // Counter only ever needs to hold MEM_TIMEOUT-1 before the FSM traps.
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [6:0] opc;
  logic [2:0] funct3;
  logic is_r, is_opi, is_ld, is_st, is_br, is_lui, is_auipc, is_jal, is_jalr;
  logic legal, tmo;
  logic unused_instr;

  assign opc    = instr[6:0];
  assign funct3 = instr[14:12];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // Opcode class decode of the current IR.
  always_comb begin
    is_r     = (opc == 7'b0110011);
    is_opi   = (opc == 7'b0010011);
    is_ld    = (opc == 7'b0000011);
    is_st    = (opc == 7'b0100011);
    is_br    = (opc == 7'b1100011);
    is_lui   = (opc == 7'b0110111);
    is_auipc = (opc == 7'b0010111);
    is_jal   = (opc == 7'b1101111);
    is_jalr  = (opc == 7'b1100111);
    legal    = is_r | is_opi | is_ld | is_st | is_br | is_lui | is_auipc |
               is_jal | is_jalr;
  end

  // Timeout fires on the last allowed wait cycle; mem_ready still takes priority.
  assign tmo = (MEM_TIMEOUT != 0) && (cnt_q == CW'(MEM_TIMEOUT - 1));

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and all control outputs from state and IR.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    reg_write = 1'b0;
    wb_sel    = 2'd0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = 4'd0;
    imm_type  = 3'd0;
    trap      = 1'b0;

    // imm_type holds from DECODE until the instruction retires.
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      if (is_opi || is_ld || is_jalr) imm_type = 3'd0;
      else if (is_st)                 imm_type = 3'd1;
      else if (is_br)                 imm_type = 3'd2;
      else if (is_lui || is_auipc)    imm_type = 3'd3;
      else if (is_jal)                imm_type = 3'd4;
    end

    // ALU selects set in EXEC stay stable while the address is in use in MEM.
    if (state_q inside {S_EXEC, S_MEM}) begin
      alu_src_a = is_auipc;
      alu_src_b = ~is_r;
      if (is_r || is_opi)
        alu_op = {instr[30] & (is_r | (funct3 == 3'b101)), funct3};
    end

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (tmo) begin
          state_d  = S_TRAP;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_ld || is_st) begin
          state_d = S_MEM;
        end else if (is_br) begin
          pc_write = 1'b1;
          pc_src   = {1'b0, br_taken};
          state_d  = S_FETCH;
        end else begin
          state_d  = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_st;
        if (mem_ready) begin
          if (is_st) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d  = S_WB;
          end
        end else if (tmo) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        if (is_ld)                 wb_sel = 2'd1;
        else if (is_jal || is_jalr) wb_sel = 2'd2;
        else if (is_lui)           wb_sel = 2'd3;
        if (is_jal)       pc_src = 2'd1;
        else if (is_jalr) pc_src = 2'd2;
        state_d = S_FETCH;
      end
      S_TRAP:  trap = 1'b1;
      default: state_d = S_TRAP;
    endcase

    // Reset forces every output quiet, even though FETCH would request memory.
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'd0;
      reg_write = 1'b0;
      wb_sel    = 2'd0;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      alu_op    = 4'd0;
      imm_type  = 3'd0;
      trap      = 1'b0;
    end
  end

  // Wait counter: restart on entering a memory-request state, count stalled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM))
      cnt_d = '0;
    else if (mem_req && !mem_ready && MEM_TIMEOUT != 0 && !tmo)
      cnt_d = cnt_q + 1'b1;
  end

  assign state = state_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_q, instret_q;

  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != S_TRAP) cycle_q   <= cycle_q + 32'd1;
      if (pc_write)          instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Self-checking bench for rv32_multicycle_ctrl: directed scenarios plus
// randomized instruction streams checked against a transaction-level model.
module tb_rv32_multicycle_ctrl;
  logic        clk, rst;
  logic [31:0] instr;
  logic        br_taken, mem_ready;
  logic        mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write;
  logic [1:0]  pc_src, wb_sel;
  logic        alu_src_a, alu_src_b, trap;
  logic [3:0]  alu_op;
  logic [2:0]  imm_type, state;

  int total = 0;
  int bad   = 0;

  rv32_multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_type(imm_type), .trap(trap), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [22:0] outs;
  assign outs = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write, wb_sel,
                 alu_src_a, alu_src_b, alu_op, imm_type, trap, state};

  // Observations of one instruction.
  int obs_states[$];
  int obs_irw, obs_memwe, obs_asel, obs_regw, obs_pcw, obs_cycles;
  int obs_imm, obs_aluop, obs_srca, obs_srcb, obs_pcsrc, obs_wbsel, obs_drift, obs_trap;

  // Expectations of one instruction.
  int exp_states[$];
  int exp_irw, exp_memwe, exp_asel, exp_regw, exp_pcw;
  int exp_imm, exp_aluop, exp_srca, exp_srcb, exp_pcsrc, exp_wbsel;

  // Acts as the memory: answers each request after the requested wait count.
  task automatic run_instr(input logic [31:0] ins, input logic bt, input int fw, input int mw);
    int waited = 0;
    int n = 0;
    bit done = 0;
    obs_states.delete();
    {obs_irw, obs_memwe, obs_asel, obs_regw, obs_pcw} = '0;
    {obs_imm, obs_aluop, obs_srca, obs_srcb, obs_pcsrc, obs_wbsel, obs_drift, obs_trap} = '0;
    instr = ins;
    br_taken = bt;
    while (!done && n < 200) begin
      mem_ready = 1'b0;
      #1;
      if (mem_req) mem_ready = (waited == (addr_sel ? mw : fw));
      #1;
      obs_states.push_back(int'(state));
      if (state == 3'd1) obs_imm = imm_type;
      if (state inside {3'd2, 3'd3, 3'd4} && imm_type != obs_imm[2:0]) obs_drift = 1;
      if (state == 3'd2) begin
        obs_aluop = alu_op; obs_srca = alu_src_a; obs_srcb = alu_src_b;
      end
      if (ir_write) obs_irw++;
      if (mem_we)   obs_memwe++;
      if (addr_sel) obs_asel++;
      if (reg_write) begin obs_regw++; obs_wbsel = wb_sel; end
      if (pc_write)  begin obs_pcw++;  obs_pcsrc = pc_src; end
      if (trap) obs_trap = 1;
      if (mem_req && !mem_ready) waited++;
      else if (mem_ready) waited = 0;
      if (pc_write || trap) done = 1;
      n++;
      @(negedge clk);
    end
    obs_cycles = n;
    if (!done) begin
      total++; bad++;
      $display("FAIL run_bound: instr=%08h did not retire within %0d cycles", ins, n);
    end
  endtask

  // Transaction-level reference: derived from instruction class and memory waits.
  task automatic model(input logic [31:0] ins, input logic bt, input int fw, input int mw);
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    bit r = (op == 7'h33), opi = (op == 7'h13), ld = (op == 7'h03), st = (op == 7'h23);
    bit br = (op == 7'h63), lui = (op == 7'h37), aui = (op == 7'h17);
    bit jal = (op == 7'h6f), jalr = (op == 7'h67);
    exp_states.delete();
    for (int i = 0; i <= fw; i++) exp_states.push_back(0);
    exp_states.push_back(1);
    exp_states.push_back(2);
    if (ld || st) for (int i = 0; i <= mw; i++) exp_states.push_back(3);
    if (!(br || st)) exp_states.push_back(4);
    exp_irw   = 1;
    exp_pcw   = 1;
    exp_memwe = st ? mw + 1 : 0;
    exp_asel  = (ld || st) ? mw + 1 : 0;
    exp_regw  = (br || st) ? 0 : 1;
    exp_imm   = st ? 1 : br ? 2 : (lui || aui) ? 3 : jal ? 4 : 0;
    exp_srca  = aui ? 1 : 0;
    exp_srcb  = r ? 0 : 1;
    if (r)        exp_aluop = {ins[30], f3};
    else if (opi) exp_aluop = {ins[30] && f3 == 3'b101, f3};
    else          exp_aluop = 0;
    exp_pcsrc = br ? int'(bt) : jal ? 1 : jalr ? 2 : 0;
    exp_wbsel = ld ? 1 : (jal || jalr) ? 2 : lui ? 3 : 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b0; br_taken = 1'b0; instr = 32'h00A0A183;
    #2;
    total++;
    if (outs !== 23'd0) begin bad++; $display("FAIL reset_init: outs=%06h want 0", outs); end
    @(negedge clk); rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (state !== 3'd3 || addr_sel !== 1'b1) begin
      bad++; $display("FAIL reset_reach_mem: state=%0d addr_sel=%0b want 3/1", state, addr_sel);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (outs !== 23'd0) begin bad++; $display("FAIL reset_async: outs=%06h want 0", outs); end
    @(posedge clk); #1;
    total++;
    if (outs !== 23'd0) begin bad++; $display("FAIL reset_held: outs=%06h want 0", outs); end
    @(negedge clk); rst = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b1 || state !== 3'd0) begin
      bad++; $display("FAIL reset_release: mem_req=%0b state=%0d want 1/0", mem_req, state);
    end
  endtask

  task automatic test_addi();
    run_instr(32'h00508113, 1'b0, 0, 0);
    total++;
    if (obs_states.size() != 4 || obs_states[0] != 0 || obs_states[1] != 1 ||
        obs_states[2] != 2 || obs_states[3] != 4) begin
      bad++; $display("FAIL addi_states: n=%0d want 0,1,2,4", obs_states.size());
    end
    total++;
    if ({obs_imm, obs_srcb, obs_aluop, obs_regw, obs_wbsel, obs_pcsrc} !== {32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd0}) begin
      bad++; $display("FAIL addi_ctrl: imm=%0d srcb=%0d aluop=%0d regw=%0d wbsel=%0d pcsrc=%0d want 0,1,0,1,0,0",
                      obs_imm, obs_srcb, obs_aluop, obs_regw, obs_wbsel, obs_pcsrc);
    end
  endtask

  task automatic test_load_wait();
    run_instr(32'h00A0A183, 1'b0, 0, 3);
    total++;
    if (obs_cycles != 8 || obs_asel != 4 || obs_memwe != 0 || obs_wbsel != 1) begin
      bad++; $display("FAIL load_wait: cycles=%0d asel=%0d memwe=%0d wbsel=%0d want 8,4,0,1",
                      obs_cycles, obs_asel, obs_memwe, obs_wbsel);
    end
  endtask

  task automatic test_store_branch();
    run_instr(32'h0050A123, 1'b0, 0, 0);
    total++;
    if (obs_cycles != 4 || obs_memwe != 1 || obs_imm != 1 || obs_pcsrc != 0 || obs_regw != 0) begin
      bad++; $display("FAIL store: cycles=%0d memwe=%0d imm=%0d pcsrc=%0d regw=%0d want 4,1,1,0,0",
                      obs_cycles, obs_memwe, obs_imm, obs_pcsrc, obs_regw);
    end
    run_instr(32'h00208463, 1'b1, 0, 0);
    total++;
    if (obs_cycles != 3 || obs_states[2] != 2 || obs_pcw != 1 || obs_pcsrc != 1 || obs_imm != 2) begin
      bad++; $display("FAIL beq_taken: cycles=%0d pcw=%0d pcsrc=%0d imm=%0d want 3,1,1,2",
                      obs_cycles, obs_pcw, obs_pcsrc, obs_imm);
    end
    run_instr(32'h00208463, 1'b0, 0, 0);
    total++;
    if (obs_cycles != 3 || obs_pcsrc != 0) begin
      bad++; $display("FAIL beq_not_taken: cycles=%0d pcsrc=%0d want 3,0", obs_cycles, obs_pcsrc);
    end
  endtask

  task automatic test_jal();
    run_instr(32'h008000EF, 1'b0, 0, 0);
    total++;
    if (obs_cycles != 4 || obs_imm != 4 || obs_wbsel != 2 || obs_pcsrc != 1) begin
      bad++; $display("FAIL jal: cycles=%0d imm=%0d wbsel=%0d pcsrc=%0d want 4,4,2,1",
                      obs_cycles, obs_imm, obs_wbsel, obs_pcsrc);
    end
  endtask

  task automatic test_illegal();
    int held = 0;
    run_instr(32'hFFFFFFFF, 1'b0, 0, 0);
    total++;
    if (obs_states.size() != 3 || obs_states[1] != 1 || obs_states[2] != 5 || obs_trap != 1) begin
      bad++; $display("FAIL illegal_trap: n=%0d trap=%0d want states 0,1,5 trap 1",
                      obs_states.size(), obs_trap);
    end
    for (int i = 0; i < 4; i++) begin
      #1;
      if (trap === 1'b1 && state === 3'd5 && outs[22:4] === '0) held++;
      @(negedge clk);
    end
    total++;
    if (held != 4) begin bad++; $display("FAIL trap_sticky: held=%0d want 4", held); end
    do_reset();
  endtask

  task automatic test_timeout();
    int n = 0;
    // Fifteen waits lands exactly on the final counter value: ready must still win.
    run_instr(32'h00508113, 1'b0, 15, 0);
    total++;
    if (obs_cycles != 19 || obs_trap != 0) begin
      bad++; $display("FAIL timeout_edge_fetch: cycles=%0d trap=%0d want 19,0", obs_cycles, obs_trap);
    end
    run_instr(32'h00A0A183, 1'b0, 0, 15);
    total++;
    if (obs_cycles != 20 || obs_trap != 0) begin
      bad++; $display("FAIL timeout_edge_mem: cycles=%0d trap=%0d want 20,0", obs_cycles, obs_trap);
    end
    // Fetch never answered.
    mem_ready = 1'b0;
    while (n < 100) begin
      #1;
      if (trap) break;
      if (mem_req) n++;
      @(negedge clk);
    end
    total++;
    if (n != 16 || state !== 3'd5) begin
      bad++; $display("FAIL timeout_fetch: req_cycles=%0d state=%0d want 16,5", n, state);
    end
    do_reset();
    // Data access never answered.
    instr = 32'h00A0A183;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (trap) break;
      if (mem_req && addr_sel) n++;
      @(negedge clk);
    end
    total++;
    if (n != 16 || state !== 3'd5) begin
      bad++; $display("FAIL timeout_mem: req_cycles=%0d state=%0d want 16,5", n, state);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [6:0] opcs [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67};
    for (int k = 0; k < 80; k++) begin
      logic [31:0] ins = $urandom;
      logic bt = 1'($urandom);
      int fw = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
      int mw = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
      bit seq_ok;
      ins[6:0] = opcs[$urandom_range(0, 8)];
      model(ins, bt, fw, mw);
      run_instr(ins, bt, fw, mw);
      seq_ok = (obs_states.size() == exp_states.size());
      if (seq_ok) foreach (exp_states[i]) if (obs_states[i] != exp_states[i]) seq_ok = 0;
      total++;
      if (!seq_ok) begin
        bad++; $display("FAIL rnd_states: instr=%08h fw=%0d mw=%0d len=%0d want len=%0d",
                        ins, fw, mw, obs_states.size(), exp_states.size());
      end
      total++;
      if ({obs_irw, obs_memwe, obs_asel, obs_regw, obs_pcw} !== {exp_irw, exp_memwe, exp_asel, exp_regw, exp_pcw}) begin
        bad++; $display("FAIL rnd_strobes: instr=%08h irw/we/asel/regw/pcw=%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                        ins, obs_irw, obs_memwe, obs_asel, obs_regw, obs_pcw,
                        exp_irw, exp_memwe, exp_asel, exp_regw, exp_pcw);
      end
      total++;
      if ({obs_imm, obs_aluop, obs_srca, obs_srcb, obs_pcsrc, obs_wbsel, obs_drift, obs_trap} !==
          {exp_imm, exp_aluop, exp_srca, exp_srcb, exp_pcsrc, exp_wbsel, 32'd0, 32'd0}) begin
        bad++; $display("FAIL rnd_selects: instr=%08h imm/op/a/b/pcs/wb/drift/trap=%0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d/%0d/0/0",
                        ins, obs_imm, obs_aluop, obs_srca, obs_srcb, obs_pcsrc, obs_wbsel, obs_drift, obs_trap,
                        exp_imm, exp_aluop, exp_srca, exp_srcb, exp_pcsrc, exp_wbsel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_wait();
    test_store_branch();
    test_jal();
    test_illegal();
    test_timeout();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
